// File: rtl/modmul_serial_if.sv
// Handshake/operand bundle for modmul_serial: the master issues start with a/b/n,
// the slave reports busy, the done pulse, the result and the operand-error flag.
interface modmul_serial_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, a, b, n,
        input  busy, done, result, err
    );

    modport slave (
        input  start, a, b, n,
        output busy, done, result, err
    );
endinterface

// File: rtl/modmul_serial.sv
// Bit-serial modular multiplier: result = (a*b) mod n, one multiplier bit per cycle, MSB first.
// Define MODMUL_SERIAL_ERRCHK_EN to reject n==0 or b>=n with err=1 and a short-circuit completion.
module modmul_serial #(
    parameter int WIDTH = 128
) (
    input logic           clk,
    input logic           reset,
    modmul_serial_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int ACC_W = WIDTH + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] n_reg, n_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             err_pend_reg, err_pend_next;
    logic             bad_ops;

`ifdef MODMUL_SERIAL_ERRCHK_EN
    assign bad_ops = (bus.n == '0) || (bus.b >= bus.n);
`else
    assign bad_ops = 1'b0;
`endif

    // One interleaved step: r = 2r + a[cnt]*b, then up to two conditional
    // subtractions of n. With r < n and b < n the sum stays below 3n.
    logic [ACC_W-1:0] stage [0:2];

    assign stage[0] = (acc_reg << 1) + (a_reg[cnt_reg] ? {2'b00, b_reg} : {ACC_W{1'b0}});

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reduce
            assign stage[gi+1] = (stage[gi] >= {2'b00, n_reg}) ? (stage[gi] - {2'b00, n_reg})
                                                              : stage[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        n_next        = n_reg;
        result_next   = result_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        err_pend_next = err_pend_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    a_next        = bus.a;
                    b_next        = bus.b;
                    n_next        = bus.n;
                    acc_next      = '0;
                    cnt_next      = CNT_W'(WIDTH - 1);
                    busy_next     = 1'b1;
                    err_next      = 1'b0;
                    err_pend_next = bad_ops;
                    if (bad_ops) begin
                        result_next = '0;
                        state_next  = ST_DONE;
                    end else begin
                        state_next  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_next = stage[2];
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == '0) begin
                    result_next = stage[2][WIDTH-1:0];
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                err_next   = err_pend_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            n_reg        <= '0;
            result_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            n_reg        <= n_next;
            result_reg   <= result_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_pend_reg <= err_pend_next;
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.err    = err_reg;
endmodule

// File: doc/modmul_serial.md
MODMUL_SERIAL -- requirements
Module: modmul_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the operand/modulus/result width in bits; legal range 8..1024.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a multiplication.
REQ-005 The block SHALL have ports a, b, n, inputs, WIDTH bits each, multiplier, multiplicand and modulus, sampled only on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-007 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-008 The block SHALL have port result, output, WIDTH bits, (a*b) mod n.
REQ-009 The block SHALL have port err, output, 1 bit, operand-check failure flag (see Configuration).

Function
REQ-010 The block SHALL compute result = (a*b) mod n by MSB-first interleaved multiplication: r=0; for i=WIDTH-1..0: r = 2r + a[i]*b, then subtract n at most twice so that r < n.
REQ-011 The internal accumulator SHALL be WIDTH+2 bits wide, so 2r+b < 3n never overflows; the reduction compares unsigned values only.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE: start=1 SHALL capture a, b and n, clear r, load the bit counter with WIDTH-1, assert busy and move to RUN.
REQ-014 RUN: each cycle SHALL process exactly one bit a[cnt] and decrement cnt; at cnt==0 it SHALL register the final r into result and move to DONE.
REQ-015 DONE: done SHALL be 1 for exactly one cycle, busy SHALL deassert, and the FSM SHALL return to IDLE.
REQ-016 Latency: with start accepted at edge T, done SHALL be high in the cycle after edge T+WIDTH+1; throughput is one operation per WIDTH+2 cycles.
REQ-017 start SHALL be ignored while busy=1 or in DONE; inputs a, b and n may change freely after acceptance.
REQ-018 result and err SHALL hold their values from done until the next accepted start, which SHALL clear err.
REQ-019 Any value of a is legal; b<n and n>0 are required for a correct result.
REQ-020 For n==1 the result SHALL be 0.

Reset
REQ-021 On reset=1 at a clock edge, the FSM SHALL go to IDLE with busy=0, done=0, err=0, result=0, the accumulator cleared and the counter set to 0.
REQ-022 Reset SHALL take priority over start and SHALL abort any in-progress operation with no done pulse.
REQ-023 In IDLE, start=1 in the first cycle after reset is deasserted SHALL be accepted.

Configuration
REQ-024 When macro MODMUL_SERIAL_ERRCHK_EN is defined, an accepted start with n==0 or b>=n SHALL skip RUN and go directly to DONE, with err=1 and result=0; done SHALL be high in the cycle after edge T+1.
REQ-025 When MODMUL_SERIAL_ERRCHK_EN is undefined, there SHALL be no checking, err SHALL be tied to 0, and out-of-range operands SHALL produce an unspecified result with normal latency.

Verification (WIDTH=8)
REQ-026 a=7, b=5, n=11 -> result=2, err=0, done in the cycle after edge T+9.
REQ-027 a=200, b=100, n=251 -> result=171; a=255, b=254, n=255 -> result=0; a=9, b=0, n=1 -> result=0.
REQ-028 Pulse start again at T+3 during RUN with different operands -> ignored, first result (2) delivered at the original time.
REQ-029 Assert reset at T+4 -> busy=0, no done pulse, result=0; a new start afterwards -> correct result with full latency.
REQ-030 With ERRCHK_EN defined: b=11, n=11 -> done at T+2, err=1, result=0; n=0 -> the same. A subsequent valid start -> err clears on acceptance.
REQ-031 Randomised regression of 10k vectors per WIDTH in {8, 64, 128} with b<n and n>0 -> result equals the reference model, with latency exactly WIDTH+2 for every vector.
